// File: rtl/booth_divider.sv
// booth_divider: sequential signed radix-2 restoring divider on operand magnitudes,
// with a final sign-correction step and the multiplier's load/done handshake.
module booth_divider #(
   parameter int DW = 16,
   parameter int VW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          done,
   output logic          busy,
   output logic          div_zero,
   output logic          ovf
);
   localparam int CW = $clog2(DW + 1);
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   state_t state, state_nxt;
   logic [VW:0] r;
   logic [DW-1:0] q;
   logic [VW-1:0] dv;
   logic [CW-1:0] count;
   logic sign_q, sign_r;
   logic accept, last;
   logic [VW:0] r_sh;
   logic [VW+1:0] diff;
   assign accept = load && (state == IDLE || state == DONE);
   assign last = count == CW'(DW - 1);
   assign busy = (state == CALC) || (state == FIX);
   // Partial remainder never exceeds |divisor|, so only its low VW bits shift up.
   assign r_sh = {r[VW-1:0], q[DW-1]};
   assign diff = {1'b0, r_sh} - {2'b0, dv};
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (load) state_nxt = (divisor == '0) ? FIX : CALC;
         CALC:       if (last) state_nxt = FIX;
         FIX:        state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r         <= '0;
         q         <= '0;
         dv        <= '0;
         count     <= '0;
         sign_q    <= 1'b0;
         sign_r    <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         done      <= 1'b0;
         div_zero  <= 1'b0;
         ovf       <= 1'b0;
      end else if (accept) begin
         sign_q   <= dividend[DW-1] ^ divisor[VW-1];
         sign_r   <= dividend[DW-1];
         q        <= dividend[DW-1] ? -dividend : dividend;
         dv       <= divisor[VW-1] ? -divisor : divisor;
         r        <= '0;
         count    <= '0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         ovf      <= 1'b0;
      end else if (state == CALC) begin
         r     <= diff[VW+1] ? r_sh : diff[VW:0];
         q     <= {q[DW-2:0], ~diff[VW+1]};
         count <= count + 1'b1;
      end else if (state == FIX) begin
         done <= 1'b1;
         if (dv == '0) begin
            quotient  <= '1;
            remainder <= '0;
            div_zero  <= 1'b1;
         end else begin
            quotient  <= sign_q ? -q : q;
            remainder <= VW'(sign_r ? -r : r);
            ovf       <= (q == {1'b1, {(DW-1){1'b0}}}) && !sign_q;
         end
      end
   end
endmodule
